// File: rtl/powlib_sfifo_if.sv
// powlib_sfifo_if
//   Bundles the producer-side and consumer-side stream signals of a
//   single-clock FIFO.
//
//   Handshake: a word moves on a rising clk edge where valid and ready are
//   both 1. Valid never depends combinationally on ready, and ready never
//   depends combinationally on valid.
//
//   Signals:
//     wrdata [W]    write data            (producer -> FIFO)
//     wrvld         write data valid      (producer -> FIFO)
//     wrrdy         FIFO can accept       (FIFO -> producer)
//     rddata [W]    head-of-FIFO data     (FIFO -> consumer)
//     rdvld         rddata holds a word   (FIFO -> consumer)
//     rdrdy         consumer accepts      (consumer -> FIFO)
//     cnt [WCNT]    current occupancy     (FIFO -> observers)
//     afull         occupancy >= AFT      (FIFO -> observers)
//
//   Modports:
//     slave  : the FIFO's own view
//     master : the view of the logic driving and draining the FIFO
interface powlib_sfifo_if #(
    parameter int W    = 16,
    parameter int WCNT = 4
);
    logic [W-1:0]    wrdata;
    logic            wrvld;
    logic            wrrdy;
    logic [W-1:0]    rddata;
    logic            rdvld;
    logic            rdrdy;
    logic [WCNT-1:0] cnt;
    logic            afull;

    modport slave (
        input  wrdata, wrvld, rdrdy,
        output wrrdy, rddata, rdvld, cnt, afull
    );

    modport master (
        output wrdata, wrvld, rdrdy,
        input  wrrdy, rddata, rdvld, cnt, afull
    );
endinterface

// File: rtl/powlib_sfifo.sv
// powlib_sfifo
//   Single-clock first-word-fall-through FIFO. Storage is a D-entry array
//   written synchronously and read asynchronously at the read pointer, so the
//   head word is visible on rddata as soon as rdvld is high. Write and read
//   pointers wrap explicitly from D-1 to 0, so any depth >= 2 works.
//   All flags are decoded from the registered occupancy count only, so there
//   is no combinational path from wrvld or rdrdy to any output.
//
//   Parameters:
//     W     data width
//     D     depth in words (>= 2, any value)
//     AFT   almost-full threshold (afull = cnt >= AFT)
//     WIDX  pointer width
//     WCNT  occupancy width (must match the interface WCNT)
//
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset (pointers and cnt only)
//     bus   powlib_sfifo_if.slave: wrdata/wrvld/wrrdy, rddata/rdvld/rdrdy,
//           cnt, afull
module powlib_sfifo #(
    parameter int W    = 16,
    parameter int D    = 8,
    parameter int AFT  = D - 1,
    parameter int WIDX = (D > 1) ? $clog2(D) : 1,
    parameter int WCNT = $clog2(D + 1)
) (
    input  logic                clk,
    input  logic                rst,
    powlib_sfifo_if.slave       bus
);

    logic [W-1:0]    mem [D];
    logic [WIDX-1:0] wrptr;
    logic [WIDX-1:0] rdptr;
    logic [WCNT-1:0] cnt_q;

    logic            wrrdy;
    logic            rdvld;
    logic            wr_en;
    logic            rd_en;

    // Flags come from the registered count only.
    assign wrrdy = (cnt_q != WCNT'(D));
    assign rdvld = (cnt_q != '0);

    // Handshakes on a reset edge are discarded.
    assign wr_en = !rst && bus.wrvld && wrrdy;
    assign rd_en = !rst && bus.rdrdy && rdvld;

    // Storage: no reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wrptr] <= bus.wrdata;
        end
    end

    // Write pointer with explicit wrap so non-power-of-2 depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr <= '0;
        end else if (wr_en) begin
            if (wrptr == WIDX'(D - 1)) begin
                wrptr <= '0;
            end else begin
                wrptr <= wrptr + WIDX'(1);
            end
        end
    end

    // Read pointer, same wrap rule.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdptr <= '0;
        end else if (rd_en) begin
            if (rdptr == WIDX'(D - 1)) begin
                rdptr <= '0;
            end else begin
                rdptr <= rdptr + WIDX'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + WCNT'(1);
                2'b01:   cnt_q <= cnt_q - WCNT'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.wrrdy  = wrrdy;
    assign bus.rdvld  = rdvld;
    assign bus.cnt    = cnt_q;
    assign bus.afull  = (int'(cnt_q) >= AFT);
    // First-word-fall-through: head word read asynchronously.
    assign bus.rddata = mem[rdptr];

endmodule

// File: tb/tb_powlib_sfifo.sv
// tb_powlib_sfifo
//   Bench for powlib_sfifo with two instances: D=8/AFT=7 (directed fill,
//   drain, full/empty corner cases, mid-stream reset) and D=5/AFT=4
//   (stalled streaming across pointer wrap). A queue model per instance
//   predicts the outputs; a negedge process compares every cycle.
module tb_powlib_sfifo;

    localparam int W     = 16;
    localparam int DA    = 8;
    localparam int AFTA  = 7;
    localparam int WCNTA = 4;
    localparam int DB    = 5;
    localparam int AFTB  = 4;
    localparam int WCNTB = 3;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;
    bit armed;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    powlib_sfifo_if #(.W(W), .WCNT(WCNTA)) if_a ();
    powlib_sfifo_if #(.W(W), .WCNT(WCNTB)) if_b ();

    powlib_sfifo #(.W(W), .D(DA), .AFT(AFTA), .WCNT(WCNTA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    powlib_sfifo #(.W(W), .D(DB), .AFT(AFTB), .WCNT(WCNTB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a plain queue per instance.
    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            armed = 1'b1;
        end else if (armed) begin
            bit wa, ra, wb, rb;
            wa = if_a.wrvld && (qa.size() != DA);
            ra = if_a.rdrdy && (qa.size() != 0);
            wb = if_b.wrvld && (qb.size() != DB);
            rb = if_b.rdrdy && (qb.size() != 0);
            if (ra) void'(qa.pop_front());
            if (wa) qa.push_back(if_a.wrdata);
            if (rb) void'(qb.pop_front());
            if (wb) qb.push_back(if_b.wrdata);
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (armed) begin
            check("a_cnt",   32'(if_a.cnt),   32'(qa.size()));
            check("a_wrrdy", 32'(if_a.wrrdy), 32'(qa.size() != DA));
            check("a_rdvld", 32'(if_a.rdvld), 32'(qa.size() != 0));
            check("a_afull", 32'(if_a.afull), 32'(qa.size() >= AFTA));
            if (qa.size() != 0) check("a_rddata", 32'(if_a.rddata), 32'(qa[0]));
            check("b_cnt",   32'(if_b.cnt),   32'(qb.size()));
            check("b_wrrdy", 32'(if_b.wrrdy), 32'(qb.size() != DB));
            check("b_rdvld", 32'(if_b.rdvld), 32'(qb.size() != 0));
            check("b_afull", 32'(if_b.afull), 32'(qb.size() >= AFTB));
            if (qb.size() != 0) check("b_rddata", 32'(if_b.rddata), 32'(qb[0]));
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        logic [W-1:0] exp_rd [9];
        int sent, rcvd, cyc;
        bit acc_w, acc_r;

        n_checks = 0;
        n_fail   = 0;
        armed    = 1'b0;
        rst      = 1'b1;
        if_a.wrdata = '0; if_a.wrvld = 1'b0; if_a.rdrdy = 1'b0;
        if_b.wrdata = '0; if_b.wrvld = 1'b0; if_b.rdrdy = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        check("rst_cnt",   32'(if_a.cnt),   32'd0);
        check("rst_wrrdy", 32'(if_a.wrrdy), 32'd1);
        check("rst_rdvld", 32'(if_a.rdvld), 32'd0);
        check("rst_afull", 32'(if_a.afull), 32'd0);

        // Idle: data changes without valid/ready
        for (int i = 0; i < 3; i++) begin
            if_a.wrdata = 16'(16'h3C00 + i);
            step();
            check("idle_cnt", 32'(if_a.cnt), 32'd0);
        end

        // Fill 1..8
        for (int i = 1; i <= 8; i++) begin
            if_a.wrdata = 16'(i);
            if_a.wrvld  = 1'b1;
            step();
            check("fill_cnt",   32'(if_a.cnt),   32'(i));
            check("fill_afull", 32'(if_a.afull), 32'(i >= 7));
            check("fill_wrrdy", 32'(if_a.wrrdy), 32'(i != 8));
        end

        // 9th write held while full
        if_a.wrdata = 16'hDEAD;
        step();
        check("full_hold_cnt", 32'(if_a.cnt),    32'd8);
        check("full_head",     32'(if_a.rddata), 32'h0001);

        // Full with simultaneous read and write: only the read happens
        if_a.rdrdy = 1'b1;
        step();
        check("fullrw_cnt",   32'(if_a.cnt),    32'd7);
        check("fullrw_wrrdy", 32'(if_a.wrrdy),  32'd1);
        check("fullrw_head",  32'(if_a.rddata), 32'h0002);
        if_a.rdrdy = 1'b0;
        step();
        check("held_accept_cnt", 32'(if_a.cnt), 32'd8);
        if_a.wrvld = 1'b0;

        // Drain: 2..8 then the held word
        for (int i = 0; i < 7; i++) exp_rd[i] = 16'(i + 2);
        exp_rd[7] = 16'hDEAD;
        if_a.rdrdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_vld",  32'(if_a.rdvld),  32'd1);
            check("drain_data", 32'(if_a.rddata), 32'(exp_rd[i]));
            step();
        end
        check("drain_empty", 32'(if_a.rdvld), 32'd0);
        check("drain_cnt",   32'(if_a.cnt),   32'd0);

        // Empty + write with consumer ready: no bypass
        if_a.wrdata = 16'h00AA;
        if_a.wrvld  = 1'b1;
        check("bypass_pre_vld", 32'(if_a.rdvld), 32'd0);
        step();
        if_a.wrvld = 1'b0;
        check("bypass_vld",  32'(if_a.rdvld),  32'd1);
        check("bypass_data", 32'(if_a.rddata), 32'h00AA);
        step();
        check("bypass_cnt", 32'(if_a.cnt),   32'd0);
        check("bypass_out", 32'(if_a.rdvld), 32'd0);
        if_a.rdrdy = 1'b0;

        // Reset mid-stream at cnt=3
        for (int i = 0; i < 3; i++) begin
            if_a.wrdata = 16'(16'h7700 + i);
            if_a.wrvld  = 1'b1;
            step();
        end
        check("mid_cnt3", 32'(if_a.cnt), 32'd3);
        if_a.wrdata = 16'h5555;
        if_a.rdrdy  = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_a.rdrdy = 1'b0;
        check("midrst_cnt", 32'(if_a.cnt),   32'd0);
        check("midrst_vld", 32'(if_a.rdvld), 32'd0);
        if_a.wrdata = 16'h1234;
        step();
        if_a.wrvld = 1'b0;
        check("midrst_first", 32'(if_a.rddata), 32'h1234);
        check("midrst_fvld",  32'(if_a.rdvld),  32'd1);
        if_a.rdrdy = 1'b1;
        step();
        if_a.rdrdy = 1'b0;
        check("midrst_drain", 32'(if_a.cnt), 32'd0);

        // D=5 stream of 20 words with random stalls
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 20 && cyc < 2000) begin
            if_b.wrvld  = (sent < 20) && ($urandom_range(0, 3) != 0);
            if_b.wrdata = 16'(16'hB000 + sent);
            if_b.rdrdy  = ($urandom_range(0, 2) != 0);
            acc_w = if_b.wrvld && if_b.wrrdy;
            acc_r = if_b.rdvld && if_b.rdrdy;
            if (acc_r) begin
                check("b_stream", 32'(if_b.rddata), 32'(16'hB000 + rcvd));
                rcvd++;
            end
            if (acc_w) sent++;
            step();
            cyc++;
        end
        if_b.wrvld = 1'b0;
        if_b.rdrdy = 1'b0;
        check("b_stream_done", 32'(rcvd), 32'd20);
        step();
        check("b_end_cnt", 32'(if_b.cnt), 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
